// File: rtl/bin_to_onehot_buf_pkg.sv
// Shared definitions for the registered binary-to-one-hot decoder with skid buffer.
package bin_to_onehot_buf_pkg;

    // Buffer occupancy.
    // EMPTY: nothing stored.
    // HALF:  OUT holds an entry.
    // FULL:  OUT and SKID both hold an entry.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HALF  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage : bin_to_onehot_buf_pkg

// File: rtl/bin_to_onehot_buf_dec.sv
// Combinational binary index to one-hot decoder.
// An index at or above ONEHOT_WIDTH sets err_o and leaves the vector all-zero,
// so it is never folded onto a legal bit.
module bin_to_onehot_buf_dec #(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
    input  logic [BIN_WIDTH-1:0]    bin_i,
    output logic [ONEHOT_WIDTH-1:0] onehot_o,
    output logic                    err_o
);

    // One extra bit so that ONEHOT_WIDTH itself is representable. This keeps
    // the range compare exact when ONEHOT_WIDTH is a power of two.
    localparam int CW = BIN_WIDTH + 1;

    logic [CW-1:0] w_bin_ext;

    assign w_bin_ext = {1'b0, bin_i};

    // Set bit k when the index equals k. Out-of-range indices match no bit.
    always_comb begin
        // NOTE: assign a default before the loop so every bit is driven on every path and no latch is inferred.
        onehot_o = '0;
        for (int k = 0; k < ONEHOT_WIDTH; k++) begin
            onehot_o[k] = (w_bin_ext == CW'(k));
        end
    end

    assign err_o = (w_bin_ext >= CW'(ONEHOT_WIDTH));

endmodule : bin_to_onehot_buf_dec

// File: rtl/bin_to_onehot_buf_sva.sv
// Interface checks for bin_to_onehot_buf. They connect only to top-level
// ports, so the module can be bound to the top or instantiated beside it.
module bin_to_onehot_buf_sva #(
    parameter int ONEHOT_WIDTH = 16
) (
    input logic                    clk_i,
    input logic                    rst_i,
    input logic                    flush_i,
    input logic                    valid_o,
    input logic                    ready_i,
    input logic [ONEHOT_WIDTH-1:0] onehot_o,
    input logic                    err_o
);

    // At most one select bit is active at any time.
    a_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(onehot_o));

    // A flagged entry never carries a select bit.
    a_err_zero: assert property (@(posedge clk_i) disable iff (rst_i)
        err_o |-> (onehot_o == '0));

    // An idle output shows no data.
    a_idle_zero: assert property (@(posedge clk_i) disable iff (rst_i)
        !valid_o |-> (onehot_o == '0) && !err_o);

    // A stalled entry holds until it is taken. A flush may still clear it.
    a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i && !flush_i) |=>
            (valid_o && $stable(onehot_o) && $stable(err_o)));

endmodule : bin_to_onehot_buf_sva

// File: rtl/bin_to_onehot_buf.sv
// Registered binary-index to one-hot decoder with valid/ready on both sides.
// A two-entry skid buffer (OUT + SKID) sustains one entry per cycle while
// ready_o comes straight from a flop, with no path from ready_i.
module bin_to_onehot_buf
    import bin_to_onehot_buf_pkg::*;
#(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [BIN_WIDTH-1:0]    bin_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [ONEHOT_WIDTH-1:0] onehot_o,
    output logic                    err_o
);

    // Parameter legality, checked at elaboration.
    if (ONEHOT_WIDTH < 2) begin : g_bad_width
        $error("bin_to_onehot_buf: ONEHOT_WIDTH must be >= 2");
    end
    if (BIN_WIDTH < $clog2(ONEHOT_WIDTH)) begin : g_bad_bin_width
        $error("bin_to_onehot_buf: BIN_WIDTH must be >= $clog2(ONEHOT_WIDTH)");
    end

    // Decode at the input so only decoded vectors are stored.
    logic [ONEHOT_WIDTH-1:0] w_dec_onehot;
    logic                    w_dec_err;

    bin_to_onehot_buf_dec #(
        .ONEHOT_WIDTH (ONEHOT_WIDTH),
        .BIN_WIDTH    (BIN_WIDTH)
    ) u_dec (
        .bin_i    (bin_i),
        .onehot_o (w_dec_onehot),
        .err_o    (w_dec_err)
    );

    // Storage and control state.
    occ_e                    r_state;
    logic                    r_ready;
    logic [ONEHOT_WIDTH-1:0] r_out_onehot;
    logic                    r_out_err;
    logic [ONEHOT_WIDTH-1:0] r_skid_onehot;
    logic                    r_skid_err;

    // Next-state values.
    occ_e                    w_state_nxt;
    logic [ONEHOT_WIDTH-1:0] w_out_onehot_nxt;
    logic                    w_out_err_nxt;
    logic [ONEHOT_WIDTH-1:0] w_skid_onehot_nxt;
    logic                    w_skid_err_nxt;

    logic                    w_in_xfer;
    logic                    w_out_xfer;

    assign w_in_xfer  = valid_i && r_ready;
    assign w_out_xfer = valid_o && ready_i;

    // Occupancy transitions and data movement between input, OUT and SKID.
    always_comb begin
        w_state_nxt       = r_state;
        w_out_onehot_nxt  = r_out_onehot;
        w_out_err_nxt     = r_out_err;
        w_skid_onehot_nxt = r_skid_onehot;
        w_skid_err_nxt    = r_skid_err;

        unique case (r_state)
            OCC_EMPTY: begin
                if (w_in_xfer) begin
                    w_out_onehot_nxt = w_dec_onehot;
                    w_out_err_nxt    = w_dec_err;
                    w_state_nxt      = OCC_HALF;
                end
            end

            OCC_HALF: begin
                if (w_in_xfer && w_out_xfer) begin
                    // The entry in OUT leaves as the new one takes its place.
                    w_out_onehot_nxt = w_dec_onehot;
                    w_out_err_nxt    = w_dec_err;
                end else if (w_in_xfer) begin
                    // OUT is stalled, so the new entry waits in SKID.
                    w_skid_onehot_nxt = w_dec_onehot;
                    w_skid_err_nxt    = w_dec_err;
                    w_state_nxt       = OCC_FULL;
                end else if (w_out_xfer) begin
                    // The last entry leaves. Clear OUT so an idle output reads zero.
                    w_out_onehot_nxt = '0;
                    w_out_err_nxt    = 1'b0;
                    w_state_nxt      = OCC_EMPTY;
                end
            end

            OCC_FULL: begin
                // ready_o is low here, so only an output transfer can occur.
                if (w_out_xfer) begin
                    w_out_onehot_nxt  = r_skid_onehot;
                    w_out_err_nxt     = r_skid_err;
                    w_skid_onehot_nxt = '0;
                    w_skid_err_nxt    = 1'b0;
                    w_state_nxt       = OCC_HALF;
                end
            end

            default: begin
                w_out_onehot_nxt  = '0;
                w_out_err_nxt     = 1'b0;
                w_skid_onehot_nxt = '0;
                w_skid_err_nxt    = 1'b0;
                w_state_nxt       = OCC_EMPTY;
            end
        endcase

        // Flush drops everything, including an input accepted this cycle.
        // An output transfer in the same cycle has already completed.
        if (flush_i) begin
            w_out_onehot_nxt  = '0;
            w_out_err_nxt     = 1'b0;
            w_skid_onehot_nxt = '0;
            w_skid_err_nxt    = 1'b0;
            w_state_nxt       = OCC_EMPTY;
        end
    end

    // State and data registers, with a synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the data registers are reset as well as the state, so onehot_o/err_o read zero straight after reset.
            r_state       <= OCC_EMPTY;
            r_ready       <= 1'b1;
            r_out_onehot  <= '0;
            r_out_err     <= 1'b0;
            r_skid_onehot <= '0;
            r_skid_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values.
            r_state       <= w_state_nxt;
            r_ready       <= (w_state_nxt != OCC_FULL);
            r_out_onehot  <= w_out_onehot_nxt;
            r_out_err     <= w_out_err_nxt;
            r_skid_onehot <= w_skid_onehot_nxt;
            r_skid_err    <= w_skid_err_nxt;
        end
    end

    assign ready_o  = r_ready;
    assign valid_o  = (r_state != OCC_EMPTY);
    assign onehot_o = r_out_onehot;
    assign err_o    = r_out_err;

endmodule : bin_to_onehot_buf

// File: tb/tb_bin_to_onehot_buf.sv
// Directed self-checking bench for bin_to_onehot_buf. It drives a 16-bit
// instance, plus a 10-bit instance that exercises out-of-range indices.
module tb_bin_to_onehot_buf;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // 16-wide instance.
    logic        rst_i, flush_i, valid_i, ready_i;
    logic [3:0]  bin_i;
    logic        ready_o, valid_o, err_o;
    logic [15:0] onehot_o;

    // 10-wide instance.
    logic        b_rst_i, b_flush_i, b_valid_i, b_ready_i;
    logic [3:0]  b_bin_i;
    logic        b_ready_o, b_valid_o, b_err_o;
    logic [9:0]  b_onehot_o;

    int checks = 0;
    int errors = 0;

    bin_to_onehot_buf #(.ONEHOT_WIDTH(16), .BIN_WIDTH(4)) u_dut16 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .bin_i    (bin_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .onehot_o (onehot_o),
        .err_o    (err_o)
    );

    bin_to_onehot_buf #(.ONEHOT_WIDTH(10), .BIN_WIDTH(4)) u_dut10 (
        .clk_i    (clk_i),
        .rst_i    (b_rst_i),
        .flush_i  (b_flush_i),
        .valid_i  (b_valid_i),
        .ready_o  (b_ready_o),
        .bin_i    (b_bin_i),
        .valid_o  (b_valid_o),
        .ready_i  (b_ready_i),
        .onehot_o (b_onehot_o),
        .err_o    (b_err_o)
    );

    bin_to_onehot_buf_sva #(.ONEHOT_WIDTH(16)) u_sva16 (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .onehot_o (onehot_o),
        .err_o    (err_o)
    );

    bin_to_onehot_buf_sva #(.ONEHOT_WIDTH(10)) u_sva10 (
        .clk_i    (clk_i),
        .rst_i    (b_rst_i),
        .flush_i  (b_flush_i),
        .valid_o  (b_valid_o),
        .ready_i  (b_ready_i),
        .onehot_o (b_onehot_o),
        .err_o    (b_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; bin_i = '0;
        b_rst_i = 1'b1; b_flush_i = 1'b0; b_valid_i = 1'b0; b_ready_i = 1'b0; b_bin_i = '0;
        step();
        step();
        rst_i = 1'b0;
        b_rst_i = 1'b0;

        // Reset state.
        check("rst_valid",  32'(valid_o),  32'd0);
        check("rst_ready",  32'(ready_o),  32'd1);
        check("rst_onehot", 32'(onehot_o), 32'd0);
        check("rst_err",    32'(err_o),    32'd0);

        // Single index.
        ready_i = 1'b1; valid_i = 1'b1; bin_i = 4'd5;
        step();
        valid_i = 1'b0;
        check("single_valid",  32'(valid_o),  32'd1);
        check("single_onehot", 32'(onehot_o), 32'h0020);
        check("single_err",    32'(err_o),    32'd0);
        step();
        check("single_pop_valid",  32'(valid_o),  32'd0);
        check("single_pop_onehot", 32'(onehot_o), 32'd0);

        // Back-to-back stream of 0..15 with no bubbles.
        for (int i = 0; i < 16; i++) begin
            valid_i = 1'b1; bin_i = 4'(i);
            step();
            check("stream_ready",  32'(ready_o),  32'd1);
            check("stream_valid",  32'(valid_o),  32'd1);
            check("stream_onehot", 32'(onehot_o), 32'(1) << i);
        end
        valid_i = 1'b0;
        step();
        check("stream_drain_valid", 32'(valid_o), 32'd0);

        // Backpressure: 3 and 7 are accepted, and 9 stalls upstream.
        ready_i = 1'b0; valid_i = 1'b1; bin_i = 4'd3;
        step();
        check("bp_ready_half", 32'(ready_o),  32'd1);
        check("bp_onehot_3",   32'(onehot_o), 32'h0008);
        bin_i = 4'd7;
        step();
        check("bp_ready_full", 32'(ready_o),  32'd0);
        check("bp_hold_3a",    32'(onehot_o), 32'h0008);
        bin_i = 4'd9;
        step();
        check("bp_ready_stall", 32'(ready_o),  32'd0);
        check("bp_hold_3b",     32'(onehot_o), 32'h0008);
        check("bp_hold_valid",  32'(valid_o),  32'd1);
        ready_i = 1'b1;
        step();
        check("bp_out_7",      32'(onehot_o), 32'h0080);
        check("bp_ready_back", 32'(ready_o),  32'd1);
        step();
        valid_i = 1'b0;
        check("bp_out_9",   32'(onehot_o), 32'h0200);
        check("bp_valid_9", 32'(valid_o),  32'd1);
        step();
        check("bp_empty_valid",  32'(valid_o),  32'd0);
        check("bp_empty_onehot", 32'(onehot_o), 32'd0);

        // Flush from FULL with an input presented in the same cycle.
        ready_i = 1'b0; valid_i = 1'b1; bin_i = 4'd2;
        step();
        bin_i = 4'd4;
        step();
        check("flush_pre_full", 32'(ready_o), 32'd0);
        flush_i = 1'b1; bin_i = 4'd6;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_valid",  32'(valid_o),  32'd0);
        check("flush_ready",  32'(ready_o),  32'd1);
        check("flush_onehot", 32'(onehot_o), 32'd0);
        check("flush_err",    32'(err_o),    32'd0);
        ready_i = 1'b1;
        step();
        check("flush_no_6", 32'(valid_o), 32'd0);

        // Flush from HALF while an input transfer is accepted and discarded.
        ready_i = 1'b0; valid_i = 1'b1; bin_i = 4'd2;
        step();
        flush_i = 1'b1; bin_i = 4'd6;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_half_valid", 32'(valid_o), 32'd0);
        check("flush_half_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        step();
        check("flush_half_no_6", 32'(valid_o), 32'd0);

        // Reset mid-stream from FULL.
        ready_i = 1'b0; valid_i = 1'b1; bin_i = 4'd2;
        step();
        bin_i = 4'd4;
        step();
        valid_i = 1'b0;
        check("mrst_pre_full", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mrst_valid",  32'(valid_o),  32'd0);
        check("mrst_ready",  32'(ready_o),  32'd1);
        check("mrst_onehot", 32'(onehot_o), 32'd0);
        ready_i = 1'b1; valid_i = 1'b1; bin_i = 4'd1;
        step();
        valid_i = 1'b0;
        check("mrst_push_valid",  32'(valid_o),  32'd1);
        check("mrst_push_onehot", 32'(onehot_o), 32'h0002);

        // Out-of-range indices on the 10-wide instance.
        b_ready_i = 1'b1; b_valid_i = 1'b1; b_bin_i = 4'd12;
        step();
        check("oor_valid",  32'(b_valid_o),  32'd1);
        check("oor_err",    32'(b_err_o),    32'd1);
        check("oor_onehot", 32'(b_onehot_o), 32'h000);
        b_bin_i = 4'd9;
        step();
        b_valid_i = 1'b0;
        check("top_onehot", 32'(b_onehot_o), 32'h200);
        check("top_err",    32'(b_err_o),    32'd0);
        step();
        check("oor_drain_valid", 32'(b_valid_o), 32'd0);
        check("oor_drain_err",   32'(b_err_o),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bin_to_onehot_buf
